// File: rtl/fft_frame_scheduler.sv
// Shares one FFT core between two sample requesters, one whole frame at a time.
// Round-robin frame grants, a core reset pulse per frame, and latency/continuity policing.
module fft_frame_scheduler #(
    parameter int FFT_SIZE   = 32,
    parameter int IN_W       = 12,
    parameter int OUT_W      = 16,
    parameter int LAT_LIMIT  = 68,
    parameter int CLR_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s0_valid,
    output logic                    s0_ready,
    input  logic signed [IN_W-1:0]  s0_din_r,
    input  logic signed [IN_W-1:0]  s0_din_i,
    input  logic                    s1_valid,
    output logic                    s1_ready,
    input  logic signed [IN_W-1:0]  s1_din_r,
    input  logic signed [IN_W-1:0]  s1_din_i,
    output logic                    core_rst_n,
    output logic                    core_in_valid,
    output logic signed [IN_W-1:0]  core_din_r,
    output logic signed [IN_W-1:0]  core_din_i,
    input  logic                    core_out_valid,
    input  logic signed [OUT_W-1:0] core_dout_r,
    input  logic signed [OUT_W-1:0] core_dout_i,
    output logic [1:0]              m_valid,
    output logic signed [OUT_W-1:0] m_dout_r,
    output logic signed [OUT_W-1:0] m_dout_i,
    output logic                    m_last,
    output logic                    busy,
    output logic                    err_underrun,
    output logic                    err_timeout
);
    localparam int CNT_MAX0 = (FFT_SIZE > LAT_LIMIT) ? FFT_SIZE : LAT_LIMIT;
    localparam int CNT_MAX  = (CNT_MAX0 > CLR_CYCLES) ? CNT_MAX0 : CLR_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT, DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               grant_reg, grant_next;
    logic [1:0]         grant_onehot, ready_vec;

    logic                    core_rst_n_reg, core_rst_n_next;
    logic                    core_in_valid_reg, core_in_valid_next;
    logic signed [IN_W-1:0]  core_din_r_reg, core_din_r_next;
    logic signed [IN_W-1:0]  core_din_i_reg, core_din_i_next;
    logic [1:0]              m_valid_reg, m_valid_next;
    logic signed [OUT_W-1:0] m_dout_r_reg, m_dout_r_next;
    logic signed [OUT_W-1:0] m_dout_i_reg, m_dout_i_next;
    logic                    m_last_reg, m_last_next;
    logic                    err_underrun_reg, err_underrun_next;
    logic                    err_timeout_reg, err_timeout_next;

    logic                   sel_valid;
    logic signed [IN_W-1:0] sel_din_r, sel_din_i;

    assign sel_valid = grant_reg ? s1_valid : s0_valid;
    assign sel_din_r = grant_reg ? s1_din_r : s0_din_r;
    assign sel_din_i = grant_reg ? s1_din_i : s0_din_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign grant_onehot[gi] = (grant_reg == 1'(gi));
        assign ready_vec[gi]    = (state_reg == LOAD) && grant_onehot[gi];
    end

    assign s0_ready = ready_vec[0];
    assign s1_ready = ready_vec[1];
    assign busy     = (state_reg != IDLE);

    // grant_reg doubles as last_grant: it keeps the owner of the previous frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            grant_reg <= grant_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        grant_next = grant_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (s0_valid || s1_valid) begin
                    state_next = CLR;
                    grant_next = (s0_valid && s1_valid) ? ~grant_reg : s1_valid;
                end
            end
            CLR: begin
                if (cnt_reg == CNT_W'(CLR_CYCLES - 1)) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            LOAD: begin
                if (!sel_valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(FFT_SIZE - 1)) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT: begin
                // data arriving on the limit cycle still counts as on time
                if (core_out_valid) begin
                    state_next = DRAIN;
                    cnt_next   = CNT_W'(1);
                end else if (cnt_reg == CNT_W'(LAT_LIMIT)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!core_out_valid || cnt_reg == CNT_W'(FFT_SIZE - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        core_rst_n_next    = (state_next != CLR);
        core_in_valid_next = 1'b0;
        core_din_r_next    = core_din_r_reg;
        core_din_i_next    = core_din_i_reg;
        m_valid_next       = 2'b00;
        m_dout_r_next      = m_dout_r_reg;
        m_dout_i_next      = m_dout_i_reg;
        m_last_next        = 1'b0;
        err_underrun_next  = 1'b0;
        err_timeout_next   = 1'b0;
        case (state_reg)
            LOAD: begin
                core_in_valid_next = sel_valid;
                core_din_r_next    = sel_din_r;
                core_din_i_next    = sel_din_i;
                err_underrun_next  = !sel_valid;
            end
            WAIT: begin
                if (core_out_valid) begin
                    m_valid_next  = grant_onehot;
                    m_dout_r_next = core_dout_r;
                    m_dout_i_next = core_dout_i;
                end else if (cnt_reg == CNT_W'(LAT_LIMIT)) begin
                    err_timeout_next = 1'b1;
                end
            end
            DRAIN: begin
                if (core_out_valid) begin
                    m_valid_next  = grant_onehot;
                    m_dout_r_next = core_dout_r;
                    m_dout_i_next = core_dout_i;
                    m_last_next   = (cnt_reg == CNT_W'(FFT_SIZE - 1));
                end else begin
                    err_timeout_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rst_n_reg    <= 1'b0;
            core_in_valid_reg <= 1'b0;
            core_din_r_reg    <= '0;
            core_din_i_reg    <= '0;
            m_valid_reg       <= 2'b00;
            m_dout_r_reg      <= '0;
            m_dout_i_reg      <= '0;
            m_last_reg        <= 1'b0;
            err_underrun_reg  <= 1'b0;
            err_timeout_reg   <= 1'b0;
        end else begin
            core_rst_n_reg    <= core_rst_n_next;
            core_in_valid_reg <= core_in_valid_next;
            core_din_r_reg    <= core_din_r_next;
            core_din_i_reg    <= core_din_i_next;
            m_valid_reg       <= m_valid_next;
            m_dout_r_reg      <= m_dout_r_next;
            m_dout_i_reg      <= m_dout_i_next;
            m_last_reg        <= m_last_next;
            err_underrun_reg  <= err_underrun_next;
            err_timeout_reg   <= err_timeout_next;
        end
    end

    assign core_rst_n    = core_rst_n_reg;
    assign core_in_valid = core_in_valid_reg;
    assign core_din_r    = core_din_r_reg;
    assign core_din_i    = core_din_i_reg;
    assign m_valid       = m_valid_reg;
    assign m_dout_r      = m_dout_r_reg;
    assign m_dout_i      = m_dout_i_reg;
    assign m_last        = m_last_reg;
    assign err_underrun  = err_underrun_reg;
    assign err_timeout   = err_timeout_reg;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: requester sources, a behavioural FFT core
// with configurable latency/length, and a negedge monitor summarised per test.
module tb_fft_frame_scheduler;
    localparam int IN_W  = 12;
    localparam int OUT_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] src_valid;
    logic signed [IN_W-1:0] src_r [2];
    logic signed [IN_W-1:0] src_i [2];
    logic s0_ready, s1_ready;
    logic core_rst_n, core_in_valid;
    logic signed [IN_W-1:0] core_din_r, core_din_i;
    logic core_out_valid;
    logic signed [OUT_W-1:0] core_dout_r, core_dout_i;
    logic [1:0] m_valid;
    logic signed [OUT_W-1:0] m_dout_r, m_dout_i;
    logic m_last, busy, err_underrun, err_timeout;

    always #5 clk = ~clk;

    fft_frame_scheduler dut (
        .clk(clk), .rst(rst),
        .s0_valid(src_valid[0]), .s0_ready(s0_ready), .s0_din_r(src_r[0]), .s0_din_i(src_i[0]),
        .s1_valid(src_valid[1]), .s1_ready(s1_ready), .s1_din_r(src_r[1]), .s1_din_i(src_i[1]),
        .core_rst_n(core_rst_n), .core_in_valid(core_in_valid),
        .core_din_r(core_din_r), .core_din_i(core_din_i),
        .core_out_valid(core_out_valid), .core_dout_r(core_dout_r), .core_dout_i(core_dout_i),
        .m_valid(m_valid), .m_dout_r(m_dout_r), .m_dout_i(m_dout_i), .m_last(m_last),
        .busy(busy), .err_underrun(err_underrun), .err_timeout(err_timeout)
    );

    // configuration written only by the main sequence
    bit src_en [2];
    int src_limit [2];
    int src_clr_req = 0;
    int mon_clr_req = 0;
    int cm_lat  = 40;
    int cm_nout = 32;

    // requester sources: sample k of requester i is i*1000+k; stop after src_limit accepts
    initial begin : src_drv
        int seq [2];
        int sent [2];
        bit acc [2];
        int clr_seen;
        clr_seen = 0;
        for (int i = 0; i < 2; i++) begin
            seq[i] = 0; sent[i] = 0; acc[i] = 1'b0;
            src_r[i] = '0; src_i[i] = '0;
        end
        src_valid = 2'b00;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    sent[i]++;
                end
            end
            if (clr_seen != src_clr_req) begin
                clr_seen = src_clr_req;
                sent[0] = 0;
                sent[1] = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (src_en[i] && sent[i] < src_limit[i]) begin
                    src_valid[i] = 1'b1;
                    src_r[i] = IN_W'(i * 1000 + seq[i]);
                    src_i[i] = IN_W'(-(i * 1000 + seq[i]));
                end else begin
                    src_valid[i] = 1'b0;
                end
                acc[i] = src_valid[i] && ((i == 0) ? s0_ready : s1_ready);
            end
        end
    end

    // core model: cm_lat cycles after the 32nd input, emit cm_nout samples 256+idx / -idx
    initial begin : core_model
        int cyc, in_cnt, start;
        cyc = 0; in_cnt = 0; start = -1000000;
        core_out_valid = 1'b0; core_dout_r = '0; core_dout_i = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!core_rst_n) begin
                in_cnt = 0;
            end else if (core_in_valid) begin
                in_cnt++;
                if (in_cnt == 32) begin
                    start  = cyc + cm_lat;
                    in_cnt = 0;
                end
            end
            if (cyc >= start && cyc < start + cm_nout) begin
                core_out_valid = 1'b1;
                core_dout_r = OUT_W'(256 + cyc - start);
                core_dout_i = OUT_W'(start - cyc);
            end else begin
                core_out_valid = 1'b0;
            end
        end
    end

    // monitor results, written only by the monitor process
    int cin_cnt, cin_runs, cin_first_r, cin_last_r, cin_last_i, cin_last_cyc;
    int crst_low, crst_runs;
    int mv_cnt, mv_first_r, mv_first_cyc, mv_last_r, mv_last_cyc, mv_tags, ml_cnt, ml_at;
    int eu_cnt, eu_civ, eu_busy, et_cnt, et_cyc;
    int grant_q [$];
    int tag_q [$];

    initial begin : monitor
        int mcyc, clr_seen;
        bit cin_prev, crst_prev, r0_prev, r1_prev;
        mcyc = 0; clr_seen = -1;
        cin_prev = 1'b0; crst_prev = 1'b0; r0_prev = 1'b0; r1_prev = 1'b0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (clr_seen != mon_clr_req) begin
                clr_seen = mon_clr_req;
                cin_cnt = 0; cin_runs = 0; cin_first_r = 0; cin_last_r = 0; cin_last_i = 0;
                cin_last_cyc = 0; crst_low = 0; crst_runs = 0;
                mv_cnt = 0; mv_first_r = 0; mv_first_cyc = 0; mv_last_r = 0; mv_last_cyc = 0;
                mv_tags = 0; ml_cnt = 0; ml_at = 0;
                eu_cnt = 0; eu_civ = 0; eu_busy = 0; et_cnt = 0; et_cyc = 0;
                grant_q.delete();
                tag_q.delete();
            end
            if (core_in_valid) begin
                if (!cin_prev) cin_runs++;
                cin_cnt++;
                if (cin_cnt == 1) cin_first_r = int'(core_din_r);
                cin_last_r = int'(core_din_r);
                cin_last_i = int'(core_din_i);
                cin_last_cyc = mcyc;
            end
            cin_prev = core_in_valid;
            if (!core_rst_n) begin
                if (crst_prev) crst_runs++;
                crst_low++;
            end
            crst_prev = core_rst_n;
            if (m_valid != 2'b00) begin
                mv_cnt++;
                if (mv_cnt == 1) begin
                    mv_first_r = int'(m_dout_r);
                    mv_first_cyc = mcyc;
                end
                mv_last_r = int'(m_dout_r);
                mv_last_cyc = mcyc;
                mv_tags = mv_tags | int'(m_valid);
            end
            if (m_last) begin
                ml_cnt++;
                ml_at = mv_cnt;
                tag_q.push_back(int'(m_valid));
            end
            if (err_underrun) begin
                eu_cnt++;
                eu_civ = int'(core_in_valid);
                eu_busy = int'(busy);
            end
            if (err_timeout) begin
                et_cnt++;
                et_cyc = mcyc;
            end
            if (s0_ready && !r0_prev) grant_q.push_back(0);
            if (s1_ready && !r1_prev) grant_q.push_back(1);
            r0_prev = s0_ready;
            r1_prev = s1_ready;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic mon_clear();
        mon_clr_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(2);
        #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main_seq
        int k;
        rst = 1'b1;
        src_en[0] = 1'b0; src_en[1] = 1'b0;
        src_limit[0] = 0; src_limit[1] = 0;
        tick(2);
        #1;
        check("rst_core_rst_n",    32'(core_rst_n), 0);
        check("rst_core_in_valid", 32'(core_in_valid), 0);
        check("rst_core_din_r",    32'(core_din_r), 0);
        check("rst_m_valid",       32'(m_valid), 0);
        check("rst_m_dout_r",      32'(m_dout_r), 0);
        check("rst_m_last",        32'(m_last), 0);
        check("rst_err",           32'({err_underrun, err_timeout}), 0);
        check("rst_ready",         32'({s1_ready, s0_ready}), 0);
        check("rst_busy",          32'(busy), 0);
        rst = 1'b0;
        tick(1);
        #1;
        check("core_rst_n_release", 32'(core_rst_n), 1);

        // single frame from requester 0, ramp 0..31, latency 40
        mon_clear();
        src_clr_req++;
        src_limit[0] = 32;
        src_en[0] = 1'b1;
        tick(200);
        check("t1_crst_low",   crst_low, 2);
        check("t1_crst_runs",  crst_runs, 1);
        check("t1_cin_cnt",    cin_cnt, 32);
        check("t1_cin_runs",   cin_runs, 1);
        check("t1_cin_first",  cin_first_r, 0);
        check("t1_cin_last_r", cin_last_r, 31);
        check("t1_cin_last_i", cin_last_i, -31);
        check("t1_mv_cnt",     mv_cnt, 32);
        check("t1_mv_tags",    mv_tags, 1);
        check("t1_mv_first",   mv_first_r, 256);
        check("t1_mv_last",    mv_last_r, 287);
        check("t1_ml_cnt",     ml_cnt, 1);
        check("t1_ml_at",      ml_at, 32);
        check("t1_lat",        mv_first_cyc - cin_last_cyc, 41);
        check("t1_errs",       eu_cnt + et_cnt, 0);
        check("t1_busy_end",   32'(busy), 0);

        // contention: both requesters continuously valid for four frames
        src_en[0] = 1'b0;
        pulse_reset();
        mon_clear();
        src_clr_req++;
        src_limit[0] = 100000;
        src_limit[1] = 100000;
        src_en[0] = 1'b1;
        src_en[1] = 1'b1;
        k = 0;
        while (tag_q.size() < 4 && k < 1200) begin
            tick(1);
            k++;
        end
        src_en[0] = 1'b0;
        src_en[1] = 1'b0;
        check("t2_frames_done", 32'(tag_q.size() >= 4), 1);
        for (int f = 0; f < 4; f++) begin
            check($sformatf("t2_grant%0d", f), (grant_q.size() > f) ? grant_q[f] : -1, f % 2);
            check($sformatf("t2_tag%0d", f),   (tag_q.size() > f) ? tag_q[f] : -1, (f % 2 == 0) ? 1 : 2);
        end
        tick(150);
        check("t2_mv_cnt", mv_cnt, 128);
        check("t2_et_cnt", et_cnt, 0);

        // underrun: requester 1 stops after 10 samples
        mon_clear();
        src_clr_req++;
        src_limit[1] = 10;
        src_en[1] = 1'b1;
        tick(100);
        check("t3_eu_cnt",  eu_cnt, 1);
        check("t3_eu_civ",  eu_civ, 0);
        check("t3_eu_busy", eu_busy, 0);
        check("t3_cin_cnt", cin_cnt, 10);
        check("t3_mv_cnt",  mv_cnt, 0);
        mon_clear();
        src_clr_req++;
        src_limit[1] = 32;
        tick(200);
        check("t3b_crst_low",  crst_low, 2);
        check("t3b_crst_runs", crst_runs, 1);
        check("t3b_cin_cnt",   cin_cnt, 32);
        check("t3b_mv_cnt",    mv_cnt, 32);
        check("t3b_mv_tags",   mv_tags, 2);
        check("t3b_ml_cnt",    ml_cnt, 1);
        check("t3b_eu_cnt",    eu_cnt, 0);
        src_en[1] = 1'b0;

        // timeout: core never answers
        cm_nout = 0;
        mon_clear();
        src_clr_req++;
        src_limit[0] = 32;
        src_en[0] = 1'b1;
        tick(200);
        check("t4_et_cnt",  et_cnt, 1);
        check("t4_et_time", et_cyc - cin_last_cyc, 69);
        check("t4_mv_cnt",  mv_cnt, 0);
        check("t4_busy",    32'(busy), 0);

        // latency exactly at the limit is accepted
        cm_lat = 68;
        cm_nout = 32;
        mon_clear();
        src_clr_req++;
        tick(250);
        check("t4b_et_cnt", et_cnt, 0);
        check("t4b_mv_cnt", mv_cnt, 32);
        check("t4b_ml_cnt", ml_cnt, 1);
        check("t4b_lat",    mv_first_cyc - cin_last_cyc, 69);
        check("t4b_last",   mv_last_r, 287);

        // one cycle beyond the limit times out
        cm_lat = 69;
        mon_clear();
        src_clr_req++;
        tick(250);
        check("t4c_et_cnt", et_cnt, 1);
        check("t4c_mv_cnt", mv_cnt, 0);

        // output gap after 20 samples
        cm_lat = 40;
        cm_nout = 20;
        mon_clear();
        src_clr_req++;
        tick(200);
        check("t5_mv_cnt",  mv_cnt, 20);
        check("t5_et_cnt",  et_cnt, 1);
        check("t5_ml_cnt",  ml_cnt, 0);
        check("t5_et_time", et_cyc - mv_last_cyc, 1);
        check("t5_last",    mv_last_r, 275);

        // asynchronous reset in the middle of LOAD
        cm_nout = 32;
        mon_clear();
        src_clr_req++;
        src_limit[0] = 100000;
        k = 0;
        while (cin_cnt < 15 && k < 200) begin
            tick(1);
            k++;
        end
        check("t6_reach_s15", 32'(cin_cnt >= 15), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_core_rst_n",    32'(core_rst_n), 0);
        check("t6_core_in_valid", 32'(core_in_valid), 0);
        check("t6_s0_ready",      32'(s0_ready), 0);
        check("t6_busy",          32'(busy), 0);
        check("t6_m_valid",       32'(m_valid), 0);
        src_limit[1] = 100000;
        src_en[1] = 1'b1;
        mon_clear();
        tick(2);
        #1;
        rst = 1'b0;
        k = 0;
        while (grant_q.size() < 2 && k < 300) begin
            tick(1);
            k++;
        end
        check("t6_grant0", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
        check("t6_grant1", (grant_q.size() > 1) ? grant_q[1] : -1, 1);
        src_en[0] = 1'b0;
        src_en[1] = 1'b0;
        tick(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
